// File: rtl/im_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, fault bit
// positions, wait-state limit and the byte-address to word-index helper.
package im_pkg;

  typedef logic [1:0] im_state_t;

  localparam im_state_t ST_IDLE = 2'd0;
  localparam im_state_t ST_WAIT = 2'd1;
  localparam im_state_t ST_RESP = 2'd2;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  localparam int WAIT_CYCLES_MAX = 7;

  // The caller truncates the result to its own index width.
  function automatic int unsigned word_index(input logic [31:0] byte_addr,
                                             input int unsigned depth);
    return (byte_addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/im_prefetch_buf.sv
// One-entry next-line buffer: byte-address tag, data word and valid flag.
// A write to the buffered word invalidates it, including one racing the fill.
module im_prefetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_en_i,
  input  logic [ADDR_W-1:0] inv_addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] tag_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en_i) begin
      valid_q <= !(inv_en_i && (inv_addr_i == fill_addr_i));
      tag_q   <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (inv_en_i && (inv_addr_i == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/im_fetch_unit.sv
// Writable instruction memory with request/response fetch handshake, wait
// states and fault reporting. Define IM_PREFETCH_EN for the next-line buffer.
module im_fetch_unit
  import im_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH       = 64,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [1:0]        fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES_MAX + 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * 4);
  // Images are preloaded by the device flow; runtime contents come from ld_*.
  localparam bit unused_init_file = (INIT_FILE != "");

  function automatic logic [1:0] calc_fault(input logic [ADDR_W-1:0] a);
    logic [1:0] f;
    f = '0;
    f[FAULT_MISALIGN] = |a[1:0];
    f[FAULT_RANGE]    = ({1'b0, a} >= LIMIT);
    return f;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'(word_index(32'(a), DEPTH));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  im_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q;
  logic [1:0]        fault_q;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_fault;
  logic              hit_take;
  logic              pf_hit;
  logic [DATA_W-1:0] pf_data;
  logic              ld_ok;

  assign ld_ok    = ld_en && (ld_addr[1:0] == 2'b00) && ({1'b0, ld_addr} < LIMIT);
  assign rd_fault = calc_fault(rd_addr);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    rd_en    = 1'b0;
    rd_addr  = pc_q;
    hit_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pc_d = pc_in;
          if (pf_hit) begin
            state_d  = ST_RESP;
            hit_take = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            rd_en   = 1'b1;
            rd_addr = pc_in;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          rd_en   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The output word is sampled only on entry to RESP, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (rd_en) begin
        fault_q <= rd_fault;
        instr_q <= (|rd_fault) ? '0 : mem_q[idx_of(rd_addr)];
      end else if (hit_take) begin
        fault_q <= '0;
        instr_q <= pf_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem_q[idx_of(ld_addr)] <= ld_data;
    end
  end

`ifdef IM_PREFETCH_EN
  logic              fill_pend_q;
  logic              fill_en;
  logic [ADDR_W-1:0] nxt_addr;
  logic              pf_valid;
  logic [ADDR_W-1:0] pf_tag;

  assign nxt_addr = pc_q + ADDR_W'(4);
  assign fill_en  = fill_pend_q && (state_q == ST_IDLE) && ({1'b0, nxt_addr} < LIMIT);
  // A request during the fill cycle must take the normal path.
  assign pf_hit   = pf_valid && !fill_pend_q && (pc_in == pf_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_pend_q <= 1'b0;
    end else begin
      fill_pend_q <= (state_q == ST_RESP) && resp_ready && (fault_q == 2'b00);
    end
  end

  im_prefetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pf_buf (
    .clk        (clk),
    .rst        (rst),
    .fill_en_i  (fill_en),
    .fill_addr_i(nxt_addr),
    .fill_data_i(mem_q[idx_of(nxt_addr)]),
    .inv_en_i   (ld_ok),
    .inv_addr_i (ld_addr),
    .valid_o    (pf_valid),
    .tag_o      (pf_tag),
    .data_o     (pf_data)
  );
`else
  assign pf_hit  = 1'b0;
  assign pf_data = '0;
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign instruction = instr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Scoreboard bench for im_fetch_unit with WAIT_CYCLES=3: stimulus pushes the
// expected response, a monitor pops and checks each response as it appears.
module tb_im_fetch_unit;

  localparam int W        = 3;
  localparam int LAT_FULL = W + 1;
`ifdef IM_PREFETCH_EN
  localparam int LAT_HIT  = 1;
`else
  localparam int LAT_HIT  = W + 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, ld_en;
  logic [31:0] pc_in, instruction, ld_addr, ld_data;
  logic [1:0]  fault;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  time  t_acc  = 0;
  event ev_acc;

  always #5 clk = ~clk;

  im_fetch_unit #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(W), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .pc_in(pc_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .instruction(instruction), .fault(fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: first cycle of a response pops the scoreboard, later cycles check stability.
  exp_t cur;
  bit   in_resp = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst && resp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got instr=%h fault=%b expected no response", instruction, fault);
          cur = '{instruction, fault, 0};
        end else begin
          cur = exp_q.pop_front();
          check("instr", instruction, cur.instr);
          check("fault", {30'b0, fault}, {30'b0, cur.fault});
          check("latency", 32'((($time - t_acc) / 10) + 1), 32'(cur.lat));
          $display("resp instr=%h fault=%b latency=%0d", instruction, fault,
                   32'((($time - t_acc) / 10) + 1));
        end
      end else begin
        check("hold_instr", instruction, cur.instr);
        check("hold_fault", {30'b0, fault}, {30'b0, cur.fault});
      end
      check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
    end else begin
      in_resp = 1'b0;
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    $display("load addr=%h data=%h", a, d);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef,
                       input int lat, input int hold);
    int n;
    exp_q.push_back('{ei, ef, lat});
    @(negedge clk);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    pc_in      = pc;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout pc=%h: got no req_ready expected accept", pc);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    -> ev_acc;
    @(negedge clk);
    req_valid = 1'b0;
    pc_in     = 32'hDEAD_BEEF;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout pc=%h: got no resp_valid expected response", pc);
      return;
    end
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    n = 0;
    while (resp_valid && n < 20) begin @(negedge clk); n++; end
    if (resp_valid) begin
      checks++; errors++;
      $display("FAIL handshake_timeout pc=%h: got resp_valid=1 expected 0", pc);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; pc_in = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_instr", instruction, 32'd0);
    check("reset_fault", {30'b0, fault}, 32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b0;

    load(32'd0,   32'hE3A00014);
    load(32'd8,   32'hE0923002);
    load(32'd12,  32'h1111_1111);
    load(32'd4,   32'hA5A5_A5A5);
    load(32'd5,   32'h5A5A_5A5A);   // misaligned: dropped
    load(32'd260, 32'h0F0F_0F0F);   // out of range: dropped
    load(32'd16,  32'hD000_0010);
    load(32'd20,  32'hD000_0014);
    load(32'd24,  32'hD000_0018);

    fetch(32'd0, 32'hE3A00014, 2'b00, LAT_FULL, 0);
    fetch(32'd8, 32'hE0923002, 2'b00, LAT_FULL, 5);
    fetch(32'd4, 32'hA5A5_A5A5, 2'b00, LAT_FULL, 0);

    fetch(32'd6,   32'd0, 2'b01, LAT_FULL, 0);
    fetch(32'd256, 32'd0, 2'b10, LAT_FULL, 0);
    fetch(32'd257, 32'd0, 2'b11, LAT_FULL, 0);

    // Load lands on the same edge that samples pc=12: old data returned.
    fork
      fetch(32'd12, 32'h1111_1111, 2'b00, LAT_FULL, 0);
      begin
        @(ev_acc);
        repeat (3) @(negedge clk);
        ld_en = 1'b1; ld_addr = 32'd12; ld_data = 32'h2222_2222;
        @(negedge clk);
        ld_en = 1'b0;
      end
    join
    fetch(32'd12, 32'h2222_2222, 2'b00, LAT_FULL, 0);

    // Reset during WAIT aborts the fetch without a response.
    @(negedge clk);
    req_valid = 1'b1; pc_in = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_instr", instruction, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    check("abort_no_resp", {31'b0, resp_valid}, 32'd0);

    fetch(32'd16, 32'hD000_0010, 2'b00, LAT_FULL, 0);
    fetch(32'd20, 32'hD000_0014, 2'b00, LAT_HIT, 0);
    load(32'd24, 32'hBEEF_0018);
    fetch(32'd24, 32'hBEEF_0018, 2'b00, LAT_FULL, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
